// File: rtl/cpu_ctrl_pkg.sv
// Shared CPU control definitions: fetch FSM state encoding and instruction width default.
// The WAIT state exists only when FETCH_WAIT_STATE_EN is defined.
package cpu_ctrl_pkg;

    localparam int unsigned IBYTES_DEFAULT = 3;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        READ,
`ifdef FETCH_WAIT_STATE_EN
        WAIT,
`endif
        CAPTURE,
        EXEC,
        BRANCH
    } fetch_state_t;

    // Memory is selected and output-enabled for the whole read access of a byte.
    function automatic logic mem_strobe(input fetch_state_t s);
        logic a;
        a = (s == READ) || (s == CAPTURE);
`ifdef FETCH_WAIT_STATE_EN
        a = a || (s == WAIT);
`endif
        return a;
    endfunction

endpackage

// File: rtl/fetch_controller.sv
// Instruction fetch controller: reads IBYTES bytes per instruction, hands off to the decoder,
// then continues, branches or halts. Define FETCH_WAIT_STATE_EN to add one memory wait cycle per byte.
module fetch_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned IBYTES = IBYTES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       halt,
    input  logic       op_rdy,
    input  logic       exec_done,
    input  logic       br_req,
    input  logic [7:0] br_addr,
    output logic       m_cs,
    output logic       m_oe,
    output logic       m_we,
    output logic       ir_rst,
    output logic       ir_en,
    output logic       pc_en,
    output logic       pc_br_en,
    output logic [7:0] pc_next_instr_addr,
    output logic       busy,
    output logic [1:0] byte_cnt,
    output logic       seq_err
);

    localparam logic [1:0] LAST_BYTE = 2'(IBYTES - 1);

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic [1:0]   cnt_nxt;

    assign m_we = 1'b0;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = byte_cnt;
        case (state)
            IDLE:    if (start) state_nxt = CLR;
            CLR: begin
                cnt_nxt   = '0;
                state_nxt = READ;
            end
`ifdef FETCH_WAIT_STATE_EN
            READ:    state_nxt = WAIT;
            WAIT:    state_nxt = CAPTURE;
`else
            READ:    state_nxt = CAPTURE;
`endif
            CAPTURE: begin
                if (byte_cnt == LAST_BYTE) begin
                    cnt_nxt   = '0;
                    state_nxt = EXEC;
                end else begin
                    cnt_nxt   = byte_cnt + 2'd1;
                    state_nxt = READ;
                end
            end
            EXEC: begin
                if (exec_done) begin
                    if (br_req)    state_nxt = BRANCH;
                    else if (halt) state_nxt = IDLE;
                    else           state_nxt = READ;
                end
            end
            BRANCH:  state_nxt = halt ? IDLE : READ;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are registered from the next state so each output is glitch-free and state-aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            byte_cnt           <= '0;
            m_cs               <= 1'b0;
            m_oe               <= 1'b0;
            ir_rst             <= 1'b0;
            ir_en              <= 1'b0;
            pc_en              <= 1'b0;
            pc_br_en           <= 1'b0;
            busy               <= 1'b0;
            seq_err            <= 1'b0;
            pc_next_instr_addr <= '0;
        end else begin
            state    <= state_nxt;
            byte_cnt <= cnt_nxt;
            m_cs     <= mem_strobe(state_nxt);
            m_oe     <= mem_strobe(state_nxt);
            ir_rst   <= (state_nxt == CLR);
            ir_en    <= (state_nxt == CAPTURE);
            pc_en    <= (state_nxt == CAPTURE);
            pc_br_en <= (state_nxt == BRANCH);
            busy     <= (state_nxt != IDLE);

            if (state == EXEC && exec_done && br_req)
                pc_next_instr_addr <= br_addr;

            if (state == CLR)
                seq_err <= 1'b0;
            else if (exec_done && (state != EXEC || !op_rdy))
                seq_err <= 1'b1;
        end
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter IBYTES, default 3, meaning bytes per instruction (legal 1..4).
REQ-002 SHALL have ports: clk  in  1  system clock (all logic on rising edge).
REQ-003 SHALL have ports: rst  in  1  synchronous active-high reset.
REQ-004 SHALL have ports: start  in  1  begin fetching from current PC; halt  in  1  stop at next instruction boundary.
REQ-005 SHALL have ports: op_rdy  in  1  instruction register full; exec_done  in  1  decoder finished current instruction (1-cycle pulse).
REQ-006 SHALL have ports: br_req  in  1  branch taken, qualified by exec_done; br_addr  in  8  branch target.
REQ-007 SHALL have ports: m_cs, m_oe, m_we  out  1 each  instruction memory strobes.
REQ-008 SHALL have ports: ir_rst, ir_en  out  1 each  instruction register clear/load; pc_en, pc_br_en  out  1 each  PC increment/load; pc_next_instr_addr  out  8  PC load value.
REQ-009 SHALL have ports: busy  out  1  not IDLE; byte_cnt  out  2  byte index within instruction; seq_err  out  1  sticky sequencing error.

Function
REQ-010 SHALL implement FSM states IDLE, CLR, READ, WAIT (macro only), CAPTURE, EXEC, BRANCH; all outputs registered or decoded from state only.
REQ-011 IDLE: all strobes 0; start=1 -> CLR; start ignored in any other state.
REQ-012 CLR: ir_rst=1 for exactly one cycle, byte_cnt<=0, seq_err<=0 -> READ.
REQ-013 READ: m_cs=1, m_oe=1 (memory data valid next cycle) -> CAPTURE (or WAIT with macro).
REQ-014 CAPTURE: m_cs=1, m_oe=1, ir_en=1, pc_en=1 each for exactly one cycle; if byte_cnt==IBYTES-1 then byte_cnt<=0 -> EXEC, else byte_cnt+1 -> READ.
REQ-015 m_we SHALL be 0 in every state; m_oe SHALL never be 1 with m_cs=0.
REQ-016 EXEC: all strobes 0; wait indefinitely for exec_done.
REQ-017 EXEC with exec_done=1: br_req=1 -> BRANCH; else halt=1 -> IDLE; else -> READ.
REQ-018 BRANCH: pc_br_en=1 one cycle, pc_next_instr_addr=br_addr captured at exec_done; then halt=1 -> IDLE else READ.
REQ-019 pc_next_instr_addr SHALL hold last captured br_addr (0x00 after reset) outside BRANCH.
REQ-020 seq_err SHALL set when exec_done=1 in EXEC with op_rdy=0, or exec_done=1 outside EXEC; cleared only by rst or CLR; FSM proceeds normally regardless.
REQ-021 halt SHALL be level-sampled only at EXEC exit/BRANCH; halt during a fetch SHALL NOT truncate the instruction.
REQ-022 PC wrap 0xFF->0x00 SHALL need no controller action; fetch continues.
REQ-023 Fetch latency, start to EXEC: 1 + 2*IBYTES cycles (1 + 3*IBYTES with macro).

Reset
REQ-024 rst=1 SHALL force IDLE next edge from any state, overriding start/exec_done.
REQ-025 Reset values: all strobes 0, busy 0, byte_cnt 0, seq_err 0, pc_next_instr_addr 0x00.
REQ-026 Reset mid-fetch SHALL leave no pending ir_en/pc_en; partial IR contents cleared by next CLR.

Configuration
REQ-027 Macro FETCH_WAIT_STATE_EN defined: READ -> WAIT -> CAPTURE, WAIT holds m_cs=1, m_oe=1, no other strobes.
REQ-028 Macro undefined: WAIT state absent from RTL, READ -> CAPTURE directly.

Structure
REQ-029 State encoding enum and IBYTES default SHALL live in shared package cpu_ctrl_pkg for decoder reuse.
REQ-030 Single module, no sub-modules; byte counter inline.

Verification
REQ-031 Reset then start pulse, IBYTES=3, no macro -> ir_rst at cycle 1, ir_en/pc_en pulses at cycles 3,5,7, EXEC at cycle 8, busy=1.
REQ-032 In EXEC, exec_done=1, br_req=1, br_addr=0x40 -> next cycle pc_br_en=1, pc_next_instr_addr=0x40, then READ.
REQ-033 halt=1 asserted mid-fetch (byte 1) -> three bytes still captured, IDLE one cycle after exec_done, busy=0.
REQ-034 exec_done with op_rdy=0 -> seq_err=1 and stays 1 until next start (CLR clears it).
REQ-035 rst=1 during CAPTURE -> next cycle IDLE, ir_en=0, pc_en=0, byte_cnt=0.
REQ-036 With FETCH_WAIT_STATE_EN -> each byte takes 3 cycles, EXEC at cycle 11 after start; m_we=0 throughout.
